// File: rtl/axi_lite_slv_regs_if.sv
// AXI4-Lite bus bundle between a master and the slave register block.
interface axi_lite_slv_regs_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   AWADDR;
    logic                AWVALID;
    logic                AWREADY;
    logic [DATA_W-1:0]   WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic                WVALID;
    logic                WREADY;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;
    logic [ADDR_W-1:0]   ARADDR;
    logic                ARVALID;
    logic                ARREADY;
    logic [DATA_W-1:0]   RDATA;
    logic [1:0]          RRESP;
    logic                RVALID;
    logic                RREADY;

    modport master (
        output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
    );
endinterface

// File: rtl/axi_lite_slv_regs.sv
// AXI4-Lite slave with four 32-bit words: a read-only result word, two
// read/write operand registers and a read-only status word.
// AW and W are buffered independently; a write commits once both are held.
module axi_lite_slv_regs #(
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    axi_lite_slv_regs_if.slave      s_axi,
    input  logic [C_DATA_WIDTH-1:0] slv_reg0,
    input  logic [3:0]              status_in,
    output logic [C_DATA_WIDTH-1:0] slv_reg1,
    output logic [C_DATA_WIDTH-1:0] slv_reg2
);
    localparam int          NB     = C_DATA_WIDTH / 8;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    // Write-side state
    logic                    aw_full_q, aw_full_d;
    logic [1:0]              aw_idx_q, aw_idx_d;
    logic                    w_full_q, w_full_d;
    logic [C_DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [NB-1:0]           w_strb_q, w_strb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    // Read-side state
    logic                    rvalid_q, rvalid_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic                    arready_q, arready_d;
    // Operand storage
    logic [C_DATA_WIDTH-1:0] reg1_q, reg1_d;
    logic [C_DATA_WIDTH-1:0] reg2_q, reg2_d;

    // Byte-lane merge of new write data into an existing register value
    function automatic logic [C_DATA_WIDTH-1:0] merge_bytes(
        input logic [C_DATA_WIDTH-1:0] old_v,
        input logic [C_DATA_WIDTH-1:0] new_v,
        input logic [NB-1:0]           strb
    );
        logic [C_DATA_WIDTH-1:0] r;
        r = old_v;
        for (int b = 0; b < NB; b++)
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    // Write channel: buffer AW/W, commit when both present, hold B until taken
    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;

        if (bvalid_q && s_axi.BREADY) bvalid_d = 1'b0;

        if (s_axi.AWVALID && awready_q) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi.AWADDR[3:2];
        end
        if (s_axi.WVALID && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.WDATA;
            w_strb_d = s_axi.WSTRB;
        end

        // Both buffers only fill while BVALID is low, so no response is pending here
        if (aw_full_q && w_full_q) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = OKAY;
            case (aw_idx_q)
                2'd1:    reg1_d  = merge_bytes(reg1_q, w_data_q, w_strb_q);
                2'd2:    reg2_d  = merge_bytes(reg2_q, w_data_q, w_strb_q);
                default: bresp_d = SLVERR;  // read-only words
            endcase
        end

        // Ready flops look at next state so they drop the cycle a buffer fills
        awready_d = !aw_full_d && !bvalid_d;
        wready_d  = !w_full_d  && !bvalid_d;
    end

    // Read channel: one outstanding read, data sampled from current (pre-commit) values
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = OKAY;

        if (rvalid_q && s_axi.RREADY) rvalid_d = 1'b0;

        if (s_axi.ARVALID && arready_q) begin
            rvalid_d = 1'b1;
            case (s_axi.ARADDR[3:2])
                2'd0:    rdata_d = slv_reg0;
                2'd1:    rdata_d = reg1_q;
                2'd2:    rdata_d = reg2_q;
                default: rdata_d = {{(C_DATA_WIDTH-4){1'b0}}, status_in};
            endcase
        end

        arready_d = !rvalid_d;
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= OKAY;
            arready_q <= 1'b0;
            reg1_q    <= '0;
            reg2_q    <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            arready_q <= arready_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
        end
    end

    assign s_axi.AWREADY = awready_q;
    assign s_axi.WREADY  = wready_q;
    assign s_axi.BVALID  = bvalid_q;
    assign s_axi.BRESP   = bresp_q;
    assign s_axi.ARREADY = arready_q;
    assign s_axi.RVALID  = rvalid_q;
    assign s_axi.RDATA   = rdata_q;
    assign s_axi.RRESP   = rresp_q;
    assign slv_reg1      = reg1_q;
    assign slv_reg2      = reg2_q;
endmodule

// File: tb/tb_axi_lite_slv_regs.sv
// Directed bench for axi_lite_slv_regs: a vector table of single transactions
// plus hand sequences for timing, ordering, back-pressure and reset corners.
module tb_axi_lite_slv_regs;
    logic        CLK = 1'b0;
    logic        RSTn;
    logic [31:0] slv_reg0;
    logic [3:0]  status_in;
    logic [31:0] slv_reg1, slv_reg2;
    int          n_pass = 0;
    int          n_total = 0;

    axi_lite_slv_regs_if #(.ADDR_W(4), .DATA_W(32)) s_axi ();

    axi_lite_slv_regs #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
        .CLK(CLK), .RSTn(RSTn), .s_axi(s_axi.slave),
        .slv_reg0(slv_reg0), .status_in(status_in),
        .slv_reg1(slv_reg1), .slv_reg2(slv_reg2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] reg0;
        logic [3:0]  status;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [31:0] exp_r1;
        logic [31:0] exp_r2;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_bus();
        s_axi.AWADDR = '0; s_axi.AWVALID = 1'b0;
        s_axi.WDATA = '0;  s_axi.WSTRB = '0; s_axi.WVALID = 1'b0;
        s_axi.BREADY = 1'b0;
        s_axi.ARADDR = '0; s_axi.ARVALID = 1'b0; s_axi.RREADY = 1'b0;
    endtask

    // AW and W offered together; waits for handshakes and the B response
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, hs_aw, hs_w;
        int n = 0;
        resp = 2'bxx;
        s_axi.AWADDR = a; s_axi.AWVALID = 1'b1;
        s_axi.WDATA = d;  s_axi.WSTRB = s; s_axi.WVALID = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            hs_aw = s_axi.AWVALID && s_axi.AWREADY;
            hs_w  = s_axi.WVALID && s_axi.WREADY;
            tick();
            n++;
            if (hs_aw) begin aw_done = 1; s_axi.AWVALID = 1'b0; end
            if (hs_w)  begin w_done = 1;  s_axi.WVALID = 1'b0; end
        end
        s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
        if (!(aw_done && w_done)) begin timeout("wr_handshake"); return; end
        n = 0;
        while (!s_axi.BVALID && n < 50) begin tick(); n++; end
        if (!s_axi.BVALID) begin timeout("wr_bvalid"); return; end
        resp = s_axi.BRESP;
        s_axi.BREADY = 1'b1;
        tick();
        s_axi.BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        bit hs;
        d = 'x; resp = 'x;
        s_axi.ARADDR = a; s_axi.ARVALID = 1'b1;
        hs = 0;
        while (!hs && n < 50) begin
            hs = s_axi.ARREADY;
            tick();
            n++;
        end
        s_axi.ARVALID = 1'b0;
        if (!hs) begin timeout("rd_handshake"); return; end
        n = 0;
        while (!s_axi.RVALID && n < 50) begin tick(); n++; end
        if (!s_axi.RVALID) begin timeout("rd_rvalid"); return; end
        d = s_axi.RDATA; resp = s_axi.RRESP;
        s_axi.RREADY = 1'b1;
        tick();
        s_axi.RREADY = 1'b0;
    endtask

    task automatic reset_dut();
        RSTn = 1'b0;
        idle_bus();
        tick(); tick();
        RSTn = 1'b1;
        tick();
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;

        // name, wr, addr, data, strb, reg0, status, resp, rdata, reg1, reg2
        vecs[0]  = '{"wr_r1",        1, 4'h4, 32'h0000_0001, 4'hF, 32'h0, 4'h0, 2'b00, 32'h0,          32'h0000_0001, 32'h0};
        vecs[1]  = '{"rd_r1",        0, 4'h4, 32'h0,         4'h0, 32'h0, 4'h0, 2'b00, 32'h0000_0001,  32'h0000_0001, 32'h0};
        vecs[2]  = '{"wr_r2_ones",   1, 4'h8, 32'hFFFF_FFFF, 4'hF, 32'h0, 4'h0, 2'b00, 32'h0,          32'h0000_0001, 32'hFFFF_FFFF};
        vecs[3]  = '{"wr_r2_strb5",  1, 4'h8, 32'h1234_5678, 4'h5, 32'h0, 4'h0, 2'b00, 32'h0,          32'h0000_0001, 32'hFF34_FF78};
        vecs[4]  = '{"rd_r2",        0, 4'h8, 32'h0,         4'h0, 32'h0, 4'h0, 2'b00, 32'hFF34_FF78,  32'h0000_0001, 32'hFF34_FF78};
        vecs[5]  = '{"wr_r2_strb0",  1, 4'h8, 32'h0000_0000, 4'h0, 32'h0, 4'h0, 2'b00, 32'h0,          32'h0000_0001, 32'hFF34_FF78};
        vecs[6]  = '{"wr_status_ro", 1, 4'hC, 32'h5555_5555, 4'hF, 32'h0, 4'h0, 2'b10, 32'h0,          32'h0000_0001, 32'hFF34_FF78};
        vecs[7]  = '{"wr_reg0_ro",   1, 4'h0, 32'h5555_5555, 4'hF, 32'h0, 4'h0, 2'b10, 32'h0,          32'h0000_0001, 32'hFF34_FF78};
        vecs[8]  = '{"rd_status",    0, 4'hC, 32'h0,         4'h0, 32'h0, 4'hA, 2'b00, 32'h0000_000A,  32'h0000_0001, 32'hFF34_FF78};
        vecs[9]  = '{"rd_reg0",      0, 4'h0, 32'h0,         4'h0, 32'hDEAD_BEEF, 4'h0, 2'b00, 32'hDEAD_BEEF, 32'h0000_0001, 32'hFF34_FF78};
        vecs[10] = '{"wr_r1_lowbits",1, 4'h6, 32'hAABB_CCDD, 4'hA, 32'h0, 4'h0, 2'b00, 32'h0,          32'hAA00_CC01, 32'hFF34_FF78};
        vecs[11] = '{"rd_r1_lowbits",0, 4'h7, 32'h0,         4'h0, 32'h0, 4'h0, 2'b00, 32'hAA00_CC01,  32'hAA00_CC01, 32'hFF34_FF78};

        slv_reg0 = 32'h0; status_in = 4'h0;
        RSTn = 1'b0;
        idle_bus();
        tick();
        // Reset state
        check("rst_awready", {31'b0, s_axi.AWREADY}, 32'd0);
        check("rst_wready",  {31'b0, s_axi.WREADY},  32'd0);
        check("rst_arready", {31'b0, s_axi.ARREADY}, 32'd0);
        check("rst_bvalid",  {31'b0, s_axi.BVALID},  32'd0);
        check("rst_rvalid",  {31'b0, s_axi.RVALID},  32'd0);
        check("rst_rdata",   s_axi.RDATA, 32'd0);
        check("rst_resps",   {28'b0, s_axi.BRESP, s_axi.RRESP}, 32'd0);
        check("rst_regs",    slv_reg1 | slv_reg2, 32'd0);
        RSTn = 1'b1;
        tick();
        check("post_rst_ready", {29'b0, s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY}, 32'h7);

        // Same-cycle AW/W: BVALID two cycles on; read at commit edge sees old value
        s_axi.AWADDR = 4'h4; s_axi.AWVALID = 1'b1;
        s_axi.WDATA = 32'h0000_0005; s_axi.WSTRB = 4'hF; s_axi.WVALID = 1'b1;
        tick();                                   // edge k: both captured
        s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
        check("a_bvalid_k1", {31'b0, s_axi.BVALID}, 32'd0);
        check("a_reg1_k1",   slv_reg1, 32'd0);
        check("a_ready_k1",  {30'b0, s_axi.AWREADY, s_axi.WREADY}, 32'd0);
        s_axi.ARADDR = 4'h4; s_axi.ARVALID = 1'b1;
        tick();                                   // edge k+1: commit + read accept
        s_axi.ARVALID = 1'b0;
        check("a_bvalid_k2", {31'b0, s_axi.BVALID}, 32'd1);
        check("a_bresp",     {30'b0, s_axi.BRESP}, 32'd0);
        check("a_reg1_k2",   slv_reg1, 32'h5);
        check("a_rd_precommit", s_axi.RDATA, 32'd0);
        check("a_rvalid",    {31'b0, s_axi.RVALID}, 32'd1);
        tick(); tick();
        check("a_bvalid_hold", {31'b0, s_axi.BVALID}, 32'd1);
        check("a_aw_blocked",  {31'b0, s_axi.AWREADY}, 32'd0);
        s_axi.BREADY = 1'b1; s_axi.RREADY = 1'b1;
        tick();
        s_axi.BREADY = 1'b0; s_axi.RREADY = 1'b0;
        check("a_b_r_done", {30'b0, s_axi.BVALID, s_axi.RVALID}, 32'd0);

        // Vector table
        for (int i = 0; i < 12; i++) begin
            slv_reg0 = vecs[i].reg0; status_in = vecs[i].status;
            if (vecs[i].is_wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
                check({vecs[i].name, "_bresp"}, {30'b0, resp}, {30'b0, vecs[i].exp_resp});
            end else begin
                do_read(vecs[i].addr, rd, resp);
                check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
                check({vecs[i].name, "_rresp"}, {30'b0, resp}, {30'b0, vecs[i].exp_resp});
            end
            check({vecs[i].name, "_reg1"}, slv_reg1, vecs[i].exp_r1);
            check({vecs[i].name, "_reg2"}, slv_reg2, vecs[i].exp_r2);
        end

        // W leads AW by three cycles: nothing commits until AW arrives
        check("b_wready", {31'b0, s_axi.WREADY}, 32'd1);
        s_axi.WDATA = 32'hC000_0001; s_axi.WSTRB = 4'hF; s_axi.WVALID = 1'b1;
        tick();
        s_axi.WVALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("b_wait_bvalid", {31'b0, s_axi.BVALID}, 32'd0);
            check("b_wait_reg2",   slv_reg2, 32'hFF34_FF78);
            check("b_wait_wready", {31'b0, s_axi.WREADY}, 32'd0);
            tick();
        end
        check("b_awready", {31'b0, s_axi.AWREADY}, 32'd1);
        s_axi.AWADDR = 4'h8; s_axi.AWVALID = 1'b1;
        tick();
        s_axi.AWVALID = 1'b0;
        check("b_bvalid_k1", {31'b0, s_axi.BVALID}, 32'd0);
        tick();
        check("b_bvalid_k2", {31'b0, s_axi.BVALID}, 32'd1);
        check("b_bresp",     {30'b0, s_axi.BRESP}, 32'd0);
        check("b_reg2",      slv_reg2, 32'hC000_0001);
        s_axi.BREADY = 1'b1;
        tick();
        s_axi.BREADY = 1'b0;

        // Read with RREADY low five cycles: response held, no new AR accepted
        slv_reg0 = 32'hDEAD_BEEF;
        s_axi.ARADDR = 4'h0; s_axi.ARVALID = 1'b1;
        tick();
        s_axi.ARVALID = 1'b0;
        slv_reg0 = 32'h1111_2222;                 // must not leak into held RDATA
        for (int c = 0; c < 5; c++) begin
            check("c_rvalid_hold",  {31'b0, s_axi.RVALID}, 32'd1);
            check("c_rdata_hold",   s_axi.RDATA, 32'hDEAD_BEEF);
            check("c_arready_low",  {31'b0, s_axi.ARREADY}, 32'd0);
            tick();
        end
        s_axi.RREADY = 1'b1;
        tick();
        s_axi.RREADY = 1'b0;
        check("c_rvalid_done", {31'b0, s_axi.RVALID}, 32'd0);
        check("c_arready_back", {31'b0, s_axi.ARREADY}, 32'd1);

        // Reset while a write response is pending
        s_axi.AWADDR = 4'h4; s_axi.AWVALID = 1'b1;
        s_axi.WDATA = 32'h0BAD_F00D; s_axi.WSTRB = 4'hF; s_axi.WVALID = 1'b1;
        tick();
        s_axi.AWVALID = 1'b0; s_axi.WVALID = 1'b0;
        tick();
        check("d_bvalid_pre", {31'b0, s_axi.BVALID}, 32'd1);
        RSTn = 1'b0;
        tick();
        RSTn = 1'b1;
        check("d_bvalid_rst", {31'b0, s_axi.BVALID}, 32'd0);
        check("d_reg1_rst",   slv_reg1, 32'd0);
        check("d_reg2_rst",   slv_reg2, 32'd0);
        check("d_ready_rst",  {29'b0, s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY}, 32'd0);
        tick();
        check("d_bvalid_after", {31'b0, s_axi.BVALID}, 32'd0);
        check("d_ready_after",  {29'b0, s_axi.AWREADY, s_axi.WREADY, s_axi.ARREADY}, 32'h7);
        do_write(4'h8, 32'h0000_00A5, 4'hF, resp);
        check("d_next_bresp", {30'b0, resp}, 32'd0);
        check("d_next_reg2",  slv_reg2, 32'h0000_00A5);
        do_read(4'h8, rd, resp);
        check("d_next_rdata", rd, 32'h0000_00A5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/axi_lite_slv_regs.md
AXI_LITE_SLV_REGS -- requirements
Module: axi_lite_slv_regs

Interface
REQ-001 SHALL have these parameters:
- C_ADDR_WIDTH, default 4, AXI address width; only bits [3:2] decode.
- C_DATA_WIDTH, default 32, AXI data width; fixed at 32.
REQ-002 SHALL have these ports:
- CLK  in  1  clock; all logic on posedge.
- RSTn  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR  in  4  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  4  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- slv_reg0  in  32  result word from user logic (read-only).
- status_in  in  4  user status bits {led_3,led_2,led_1,led_0}.
- slv_reg1  out  32  operand register 1 to user logic.
- slv_reg2  out  32  operand register 2 to user logic.

Function
REQ-003 SHALL use this register map, address bits [1:0] ignored:
- 0x0: slv_reg0, RO.
- 0x4: slv_reg1, RW.
- 0x8: slv_reg2, RW.
- 0xC: {28'h0, status_in}, RO.
REQ-004 SHALL assert AWREADY while no write address is buffered and BVALID is low; an AWVALID&&AWREADY edge captures AWADDR into the address buffer.
REQ-005 SHALL assert WREADY while no write data is buffered and BVALID is low; a WVALID&&WREADY edge captures WDATA and WSTRB into the data buffer.
REQ-006 SHALL accept AW and W independently, in either order or in the same cycle.
REQ-007 SHALL commit a write at the first edge where both buffers are full.
- Commit updates the target register, clears both buffers and sets BVALID.
- Result: same-cycle AW/W handshakes at edge k give updated slv_reg1/2 and BVALID=1 from cycle k+2.
REQ-008 SHALL update only the bytes whose WSTRB bit is set; WSTRB=4'b0000 leaves the register unchanged with BRESP=OKAY.
REQ-009 SHALL respond to a write to 0x0 or 0xC with BRESP=2'b10 (SLVERR) and change no state; writes to 0x4 or 0x8 return BRESP=2'b00.
REQ-010 SHALL hold BVALID and BRESP stable until BVALID&&BREADY, then clear BVALID at that edge; AWREADY and WREADY stay low while BVALID=1.
REQ-011 SHALL assert ARREADY while RVALID is low.
REQ-012 SHALL, on an ARVALID&&ARREADY handshake at edge k, register RDATA from the map values sampled at edge k and present RVALID=1 with RRESP=2'b00 from cycle k+1.
REQ-013 SHALL hold RDATA and RVALID stable until RVALID&&RREADY, clearing RVALID at that edge; ARREADY is low while RVALID=1, giving at most one read outstanding.
REQ-014 SHALL give a read accepted at the same edge as a write commit to the same register the pre-commit value.
REQ-015 SHALL run the read and write channels concurrently with no mutual stalling.
REQ-016 SHALL drive slv_reg1 and slv_reg2 directly from their storage registers, with no extra output pipeline stage.

Reset
REQ-017 SHALL, at any edge with RSTn=0, set:
- slv_reg1=0 and slv_reg2=0;
- AWREADY=0, WREADY=0, ARREADY=0;
- BVALID=0, RVALID=0;
- BRESP=0, RRESP=0, RDATA=0;
- both write buffers empty.
REQ-018 SHALL drop any in-flight transaction on reset mid-operation, with no commit and no response issued afterward; the READY outputs rise on the first cycle after RSTn returns high.

Verification
REQ-019 SHALL pass these directed scenarios:
- Reset, then AW=0x4 and W=0x0000_0001 with WSTRB=0xF in the same cycle, BREADY=1 -> BVALID with BRESP=00 two cycles later; slv_reg1=0x0000_0001.
- W=0xC000_0001 issued 3 cycles before AW=0x8 -> no commit until AW accepted; then slv_reg2=0xC000_0001, BRESP=00.
- slv_reg2=0xFFFF_FFFF, then write 0x8 with data 0x1234_5678 and WSTRB=0x5 -> slv_reg2=0xFF34_FF78.
- Write to 0xC -> BRESP=10; read 0xC with status_in=4'b1010 -> RDATA=0x0000_000A, RRESP=00.
- Read 0x0 with slv_reg0=0xDEAD_BEEF and RREADY held low 5 cycles -> RVALID and RDATA stable, ARREADY=0 throughout; one-cycle RREADY completes the read.
- RSTn=0 for one cycle while BVALID=1 -> BVALID=0 afterward and slv_reg1/2=0; next transaction completes normally.
